// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: default widths, FSM state
// type, saturation limits and the product sign-extension helper.
package mult_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

  // Widen a signed product to accumulator width by replicating its sign bit.
  function automatic logic [ACC_W_DEF-1:0] sign_ext_prod(input logic [PROD_W_DEF-1:0] p);
    return {{(ACC_W_DEF-PROD_W_DEF){p[PROD_W_DEF-1]}}, p};
  endfunction

endpackage

// File: rtl/product_accumulator_acc_saturate.sv
// Final-sum narrowing: checks whether the ACC_W accumulator value fits in a
// PROD_W signed result and produces either the wrapped low bits or, when
// PRODUCT_ACC_SAT_EN is defined, a clamped value. Purely combinational.
module acc_saturate
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic              acc_ovf_i,
`ifdef PRODUCT_ACC_SAT_EN
  input  logic              ovf_sign_i,
`endif
  output logic [PROD_W-1:0] sum_o,
  output logic              overflow_o
);

  // Bits from the result MSB upward; all equal means the value fits.
  logic [ACC_W-PROD_W:0] top_bits;
  logic                  in_range;
`ifdef PRODUCT_ACC_SAT_EN
  logic                  sat_neg;
`endif

  // Range check, overflow flag and clamp/wrap selection.
  always_comb begin
    top_bits   = acc_i[ACC_W-1:PROD_W-1];
    in_range   = (top_bits == '0) || (top_bits == '1);
    overflow_o = acc_ovf_i | ~in_range;
`ifdef PRODUCT_ACC_SAT_EN
    // A wrapped accumulator has an unreliable MSB, so the sign recorded at
    // the overflowing add decides the clamp direction instead.
    sat_neg = acc_ovf_i ? ovf_sign_i : acc_i[ACC_W-1];
    if (overflow_o) begin
      sum_o = sat_neg ? PROD_W'(SAT_NEG) : PROD_W'(SAT_POS);
    end else begin
      sum_o = acc_i[PROD_W-1:0];
    end
`else
    sum_o = acc_i[PROD_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Product accumulator: sums a valid/ready stream of signed multiplier products
// into a guarded accumulator and emits one result per in_last-terminated
// stream with a beat count and overflow flag. Optional macro
// PRODUCT_ACC_SAT_EN clamps out-of-range results instead of wrapping.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  acc_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0]        count_q, count_d, count_inc;
  logic                    acc_ovf_q, acc_ovf_d;
  logic                    add_ovf, acc_ovf_next;
`ifdef PRODUCT_ACC_SAT_EN
  logic                    ovf_sign_q, ovf_sign_d, ovf_sign_next;
`endif
  // Holds in_ready low while in reset and releases it on the first edge after.
  logic                    alive_q, alive_d;

  logic [PROD_W-1:0]       out_sum_q, out_sum_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_overflow_q, out_overflow_d;

  logic [PROD_W-1:0]       sat_sum;
  logic                    sat_ovf;
  logic                    accept;

  // Next accumulator value, add-overflow detection and saturating beat count.
  always_comb begin
    prod_ext     = sign_ext_prod(in_product);
    sum_next     = acc_q + prod_ext;
    add_ovf      = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum_next[ACC_W-1] != acc_q[ACC_W-1]);
    acc_ovf_next = acc_ovf_q | add_ovf;
`ifdef PRODUCT_ACC_SAT_EN
    ovf_sign_next = add_ovf ? acc_q[ACC_W-1] : ovf_sign_q;
`endif
    count_inc    = (&count_q) ? count_q : count_q + CNT_W'(1);
  end

  // The result is narrowed from the post-add value so it can be registered
  // on the same edge that accepts the last beat.
  acc_saturate #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_saturate (
    .acc_i      (sum_next),
    .acc_ovf_i  (acc_ovf_next),
`ifdef PRODUCT_ACC_SAT_EN
    .ovf_sign_i (ovf_sign_next),
`endif
    .sum_o      (sat_sum),
    .overflow_o (sat_ovf)
  );

  assign in_ready     = alive_q && (state_q != DRAIN);
  assign out_valid    = (state_q == DRAIN);
  assign accept       = in_valid && in_ready;
  assign out_sum      = out_sum_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_overflow_q;

  // FSM next state plus accumulator and result-register updates.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    count_d        = count_q;
    acc_ovf_d      = acc_ovf_q;
`ifdef PRODUCT_ACC_SAT_EN
    ovf_sign_d     = ovf_sign_q;
`endif
    alive_d        = 1'b1;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;

    if (clear) begin
      // Abort wins over everything; the last result stays visible.
      state_d   = IDLE;
      acc_d     = '0;
      count_d   = '0;
      acc_ovf_d = 1'b0;
`ifdef PRODUCT_ACC_SAT_EN
      ovf_sign_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d     = sum_next;
            count_d   = count_inc;
            acc_ovf_d = acc_ovf_next;
`ifdef PRODUCT_ACC_SAT_EN
            ovf_sign_d = ovf_sign_next;
`endif
            if (in_last) begin
              state_d        = DRAIN;
              out_sum_d      = sat_sum;
              out_count_d    = count_inc;
              out_overflow_d = sat_ovf;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state_d   = IDLE;
            acc_d     = '0;
            count_d   = '0;
            acc_ovf_d = 1'b0;
`ifdef PRODUCT_ACC_SAT_EN
            ovf_sign_d = 1'b0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, accumulator and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      count_q        <= '0;
      acc_ovf_q      <= 1'b0;
`ifdef PRODUCT_ACC_SAT_EN
      ovf_sign_q     <= 1'b0;
`endif
      alive_q        <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      acc_ovf_q      <= acc_ovf_d;
`ifdef PRODUCT_ACC_SAT_EN
      ovf_sign_q     <= ovf_sign_d;
`endif
      alive_q        <= alive_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed streams plus randomized streams
// checked against an exact wide-integer model of the stream sum.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_overflow;
  logic [63:0] in_product, out_sum;
  logic [15:0] out_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] stim_q[$];
  logic [63:0] exp_sum;
  logic [15:0] exp_cnt;
  logic        exp_ovf;

  localparam logic signed [127:0] HI = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] LO = -(128'sh8000_0000_0000_0000);

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Exact sum of the stream in 128 bits; the result is out of range when the
  // exact sum does not fit a 64-bit signed value.
  task automatic model();
    logic signed [127:0] s;
    s = '0;
    foreach (stim_q[i]) s = s + {{64{stim_q[i][63]}}, stim_q[i]};
    exp_cnt = 16'(stim_q.size());
    exp_ovf = (s > HI) || (s < LO);
`ifdef PRODUCT_ACC_SAT_EN
    if (exp_ovf) exp_sum = (s < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    else         exp_sum = s[63:0];
`else
    exp_sum = s[63:0];
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input int gap_max);
    int gaps;
    for (int i = 0; i < stim_q.size(); i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid   = 1'b0;
        in_product = {$urandom, $urandom};
        in_last    = 1'($urandom);
        tick();
      end
      in_valid   = 1'b1;
      in_product = stim_q[i];
      in_last    = (i == stim_q.size() - 1);
      chk("in_ready_beat", in_ready, 1);
      chk("no_early_valid", out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    model();
    chk("out_valid_lat1", out_valid, 1);
    chk("out_sum", out_sum, exp_sum);
    chk("out_count", out_count, exp_cnt);
    chk("out_overflow", out_overflow, exp_ovf);
  endtask

  task automatic drain(input int delay);
    for (int d = 0; d < delay; d++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, exp_sum);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drained_valid", out_valid, 0);
    chk("drained_in_ready", in_ready, 1);
    chk("retain_sum", out_sum, exp_sum);
  endtask

  initial begin
    logic signed [63:0] tmp;
    int                 v, len, mode;

    reset_n    = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_product = '0;
    out_ready  = 1'b0;

    // Reset values while reset_n is low.
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_overflow", out_overflow, 0);
    #9;
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // 6 + (-15) + 100 = 91.
    stim_q = '{64'd6, 64'hFFFF_FFFF_FFFF_FFF1, 64'd100};
    send_stream(0);
    chk("basic_sum_91", out_sum, 64'd91);
    drain(0);

    // Single most-negative beat.
    stim_q = '{64'h8000_0000_0000_0000};
    send_stream(0);
    chk("single_neg_sum", out_sum, 64'h8000_0000_0000_0000);
    chk("single_cnt", out_count, 16'd1);
    chk("single_ovf", out_overflow, 0);
    drain(1);

    // Two max-positive beats overflow the 64-bit result.
    stim_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
    send_stream(0);
    chk("pos_ovf_flag", out_overflow, 1);
`ifdef PRODUCT_ACC_SAT_EN
    chk("pos_ovf_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("pos_ovf_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
`endif
    drain(0);

    // Back-pressure: result pending while upstream keeps presenting beats.
    stim_q = '{64'd1, 64'd2, 64'd3};
    send_stream(0);
    in_valid   = 1'b1;
    in_product = {$urandom, $urandom};
    in_last    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 64'd6);
      chk("bp_out_count", out_count, 16'd3);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    in_product = 64'd42;
    in_last    = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_fresh_valid", out_valid, 1);
    chk("bp_fresh_sum", out_sum, 64'd42);
    chk("bp_fresh_cnt", out_count, 16'd1);
    exp_sum = 64'd42;
    drain(0);

    // Clear mid-stream discards the partial sum and the same-cycle beat.
    in_valid   = 1'b1;
    in_last    = 1'b0;
    in_product = 64'd10;
    tick();
    in_product = 64'd20;
    tick();
    clear      = 1'b1;
    in_product = 64'd5;
    in_last    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("clr_no_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_keep_sum", out_sum, 64'd42);
    chk("clr_keep_cnt", out_count, 16'd1);
    tick();
    chk("clr_no_valid2", out_valid, 0);
    stim_q = '{64'd7};
    send_stream(0);
    chk("clr_new_sum", out_sum, 64'd7);
    drain(0);

    // Asynchronous reset mid-stream at a non-edge time.
    in_valid   = 1'b1;
    in_last    = 1'b0;
    in_product = 64'd1;
    tick();
    in_product = 64'd2;
    tick();
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", out_sum, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_out_overflow", out_overflow, 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("arst_ready_back", in_ready, 1);
    stim_q = '{64'd3};
    send_stream(0);
    chk("arst_new_sum", out_sum, 64'd3);
    drain(0);

    // Randomized streams with idle gaps and random drain delays.
    for (int s = 0; s < 25; s++) begin
      stim_q.delete();
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        mode = int'($urandom_range(0, 2));
        if (mode == 0) begin
          v   = int'($urandom_range(0, 2000)) - 1000;
          tmp = v;
          stim_q.push_back(tmp);
        end else if (mode == 1) begin
          stim_q.push_back({$urandom, $urandom});
        end else begin
          v = int'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) stim_q.push_back(64'h7FFF_FFFF_FFFF_FFFF - 64'(v));
          else                           stim_q.push_back(64'h8000_0000_0000_0000 + 64'(v));
        end
      end
      send_stream(2);
      drain(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
